// File: rtl/clk_ce_rst_gen.sv
// clk_ce_rst_gen: PLL-lock reset stretcher and single-clock enable generator
module clk_ce_rst_gen #(
    parameter int RST_CYCLES  = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic [1:0] turbo,
    output logic       rst_out,
    output logic       ce_28m,
    output logic       ce_14m,
    output logic       ce_7m,
    output logic       ce_cpu,
    output logic [1:0] turbo_q
);
    localparam int SW = $clog2(RST_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [SW-1:0]          stretch;
    logic [4:0]             cnt;
    logic [4:0]             cnt_nx;
    logic                   lock_s;
    logic                   cpu_nx;
    assign lock_s = sync[SYNC_STAGES-1];
    assign cnt_nx = cnt + 5'd1;
    // CPU enable for the upcoming count at the rate currently in force
    always_comb cpu_nx = turbo_q == 2'd0 ? &cnt_nx :
                         turbo_q == 2'd1 ? &cnt_nx[3:0] :
                         turbo_q == 2'd2 ? &cnt_nx[2:0] : &cnt_nx[1:0];
    // Lock flag synchronizer into the clk_sys domain
    always_ff @(posedge clk_sys) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], pll_locked};
    end
    // Reset stretch, divider, enables decoded one count ahead so each pulse lines up with its cnt value, turbo latched at wrap
    always_ff @(posedge clk_sys) begin
        if (reset || !lock_s) begin
            rst_out <= 1'b1;
            stretch <= '0;
            cnt     <= '0;
            ce_28m  <= 1'b0;
            ce_14m  <= 1'b0;
            ce_7m   <= 1'b0;
            ce_cpu  <= 1'b0;
            turbo_q <= 2'd0;
        end else if (rst_out) begin
            stretch <= stretch + SW'(1);
            if (stretch == SW'(RST_CYCLES - 1)) rst_out <= 1'b0;
        end else begin
            cnt    <= cnt_nx;
            ce_28m <= &cnt_nx[1:0];
            ce_14m <= &cnt_nx[2:0];
            ce_7m  <= &cnt_nx[3:0];
            ce_cpu <= cpu_nx;
            if (&cnt) turbo_q <= turbo;
        end
    end
endmodule
